// File: rtl/bus_wait_gen.sv
// Drives the 6809 nWAIT stretch request for a slow I/O address window, optionally extended while the peripheral is busy.
// Latency: nWAIT falls one MHZ48 cycle after nQ falls; no backpressure, DEV_BUSY only lengthens the stretch up to a timeout.
module bus_wait_gen #(
  parameter logic [7:0] SLOW_MASK     = 8'hF0,
  parameter logic [7:0] SLOW_MATCH    = 8'hE0,
  parameter int         WAIT_TICKS    = 24,
  parameter int         TIMEOUT_TICKS = 240,
  parameter int         CNT_W         = 8
) (
  input  logic       MHZ48,
  input  logic       RESET,
  input  logic       nQ,
  input  logic       nE,
  input  logic [7:0] ADDR,
  input  logic       BA,
  input  logic       DEV_BUSY,
  input  logic       CLR_TIMEOUT,
  output logic       nWAIT,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {IDLE, STRETCH, EXTEND, DRAIN} state_t;

  localparam bit STRETCH_EN = (WAIT_TICKS != 0);
  localparam bit EXTEND_EN  = (TIMEOUT_TICKS != 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD    = STRETCH_EN ? CNT_W'(WAIT_TICKS - 1) : '0;
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = EXTEND_EN ? CNT_W'(TIMEOUT_TICKS - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] tcnt, tcnt_nx;
  logic             nwait_nx;
  logic             timeout_set;
  logic             nq_d, ne_d;
  logic             q_rise, e_fall, slow_hit;

  assign q_rise   = nq_d & ~nQ;
  assign e_fall   = ~ne_d & nE;
  assign slow_hit = ((ADDR & SLOW_MASK) == SLOW_MATCH);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    tcnt_nx     = tcnt;
    nwait_nx    = nWAIT;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        nwait_nx = 1'b1;
        // nE high means E is low: only trigger in the first half of the bus cycle
        if (q_rise && !BA && nE && slow_hit && STRETCH_EN) begin
          state_nx = STRETCH;
          cnt_nx   = WAIT_LOAD;
          nwait_nx = 1'b0;
        end
      end
      STRETCH: begin
        if (cnt == '0) begin
          if (DEV_BUSY && EXTEND_EN) begin
            state_nx = EXTEND;
            tcnt_nx  = TIMEOUT_LOAD;
          end else begin
            state_nx = DRAIN;
            nwait_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      EXTEND: begin
        // a release on the final count wins over the timeout
        if (!DEV_BUSY) begin
          state_nx = DRAIN;
          nwait_nx = 1'b1;
        end else if (tcnt == '0) begin
          state_nx    = DRAIN;
          nwait_nx    = 1'b1;
          timeout_set = 1'b1;
        end else begin
          tcnt_nx = tcnt - CNT_ONE;
        end
      end
      DRAIN: begin
        nwait_nx = 1'b1;
        if (e_fall) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        nwait_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge MHZ48) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      nWAIT   <= 1'b1;
      TIMEOUT <= 1'b0;
      nq_d    <= 1'b1;
      ne_d    <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tcnt    <= tcnt_nx;
      nWAIT   <= nwait_nx;
      TIMEOUT <= timeout_set | (TIMEOUT & ~CLR_TIMEOUT);
      nq_d    <= nQ;
      ne_d    <= nE;
    end
  end

endmodule

// File: tb/tb_bus_wait_gen.sv
// Directed bench for bus_wait_gen: free-running 4-phase nQ/nE pattern, stretch lengths checked through a scoreboard queue.
// A second instance built with WAIT_TICKS=0 shares the inputs and must never pull nWAIT low.
module tb_bus_wait_gen;

  logic       clk = 1'b0;
  logic       rst, nq, ne, ba, busy, clr;
  logic [7:0] addr;
  logic       nwait, tmo, nwait0, tmo0;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  int exp_q[$];
  int exp_pulses = 0;
  int npulses = 0;
  int low_len = 0, hi_len = 0, gap_len = 0, dut0_low = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  bus_wait_gen dut (
    .MHZ48(clk), .RESET(rst), .nQ(nq), .nE(ne), .ADDR(addr), .BA(ba),
    .DEV_BUSY(busy), .CLR_TIMEOUT(clr), .nWAIT(nwait), .TIMEOUT(tmo)
  );

  bus_wait_gen #(.WAIT_TICKS(0)) dut0 (
    .MHZ48(clk), .RESET(rst), .nQ(nq), .nE(ne), .ADDR(addr), .BA(ba),
    .DEV_BUSY(busy), .CLR_TIMEOUT(clr), .nWAIT(nwait0), .TIMEOUT(tmo0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int len);
    exp_q.push_back(len);
    exp_pulses++;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (nwait !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, nwait === 1'b0}, 1);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (nwait !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, nwait === 1'b1}, 1);
  endtask

  // pos 0-1: Q0 E0, 2-3: Q1 E0, 4-5: Q1 E1, 6-7: Q0 E1
  initial begin
    nq = 1'b1;
    ne = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % 8;
      nq  = !(pos >= 2 && pos <= 5);
      ne  = !(pos >= 4);
    end
  end

  always @(negedge clk) begin
    if (nwait0 === 1'b0) dut0_low++;
    if (mon_en) begin
      if (nwait === 1'b0) begin
        if (low_len == 0) begin
          gap_len = hi_len;
          npulses++;
        end
        low_len++;
      end else begin
        if (low_len != 0) begin
          check("sb_expected_pulse", {31'd0, exp_q.size() != 0}, 1);
          if (exp_q.size() != 0) check("stretch_len", low_len, exp_q.pop_front());
          low_len = 0;
          hi_len  = 0;
        end
        hi_len++;
      end
    end
  end

  initial begin
    rst = 1'b1; ba = 1'b0; busy = 1'b0; clr = 1'b0; addr = 8'h12;
    repeat (4) @(negedge clk);
    check("rst_nwait", nwait, 1);
    check("rst_timeout", tmo, 0);
    check("rst_nwait0", nwait0, 1);
    rst = 1'b0;
    mon_en = 1'b1;

    // basic stretch, two consecutive bus cycles
    addr = 8'hE4;
    push(24); push(24);
    wait_start("t1_start1");
    check("t1_latency_pos", pos, 3);
    wait_end("t1_end1");
    wait_start("t1_start2");
    addr = 8'h12;
    @(negedge clk);
    check("t1_gap", gap_len, 8);
    wait_end("t1_end2");

    // no match, then match with BA=1
    repeat (80) @(negedge clk);
    check("t2_nomatch", npulses, exp_pulses);
    addr = 8'hE4; ba = 1'b1;
    repeat (80) @(negedge clk);
    check("t2_ba", npulses, exp_pulses);
    addr = 8'h12; ba = 1'b0;
    repeat (4) @(negedge clk);

    // busy 50 cycles after trigger
    addr = 8'hE4;
    push(51);
    wait_start("t3_start");
    addr = 8'h12; busy = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk); busy = 1'b0;
    wait_end("t3_end");
    check("t3_timeout", tmo, 0);

    // busy released exactly at the stretch end
    addr = 8'hE4;
    push(24);
    wait_start("t3b_start");
    addr = 8'h12; busy = 1'b1;
    repeat (23) @(posedge clk);
    @(negedge clk); busy = 1'b0;
    wait_end("t3b_end");

    // release just before a Q rise: drain must hold off the retrigger
    addr = 8'hE4;
    push(47); push(24);
    wait_start("t3c_start1");
    busy = 1'b1;
    repeat (46) @(posedge clk);
    @(negedge clk); busy = 1'b0;
    wait_end("t3c_end1");
    wait_start("t3c_start2");
    addr = 8'h12;
    @(negedge clk);
    check("t3c_gap", gap_len, 9);
    wait_end("t3c_end2");

    // busy drops on the final timeout count
    addr = 8'hE4;
    push(264);
    wait_start("t4_start");
    addr = 8'h12; busy = 1'b1;
    repeat (263) @(posedge clk);
    @(negedge clk); busy = 1'b0;
    wait_end("t4_end");
    check("t4_timeout", tmo, 0);

    // full timeout, sticky flag, clear
    addr = 8'hE4;
    push(264);
    wait_start("t5_start");
    addr = 8'h12; busy = 1'b1;
    wait_end("t5_end");
    busy = 1'b0;
    check("t5_timeout_set", tmo, 1);
    repeat (20) @(negedge clk);
    check("t5_timeout_sticky", tmo, 1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("t5_timeout_clr", tmo, 0);

    // clear on the timeout edge loses to the set
    addr = 8'hE4;
    push(264);
    wait_start("t6_start");
    addr = 8'h12; busy = 1'b1;
    repeat (263) @(posedge clk);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("t6_release", nwait, 1);
    check("t6_timeout_set_wins", tmo, 1);
    busy = 1'b0;

    // reset ten cycles into a stretch
    addr = 8'hE4;
    push(10); push(24);
    wait_start("t7_start1");
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t7_nwait_after_rst", nwait, 1);
    check("t7_timeout_after_rst", tmo, 0);
    wait_start("t7_start2");
    addr = 8'h12;
    wait_end("t7_end2");

    repeat (20) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("pulse_count", npulses, exp_pulses);
    check("wait0_never_low", dut0_low, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
